// File: rtl/coef_regfile_2r2w.sv
// rtl/coef_regfile_2r2w.sv - 2-read/2-write flop coefficient register file with sweep clear
// Port B wins same-address write collisions; a clear sweep zeroes one word per cycle.
module coef_regfile_2r2w #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 8,
    parameter int RD_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addrw_a,
    input  logic [ADDR_W-1:0] addrw_b,
    input  logic [DATA_W-1:0] din_a,
    input  logic [DATA_W-1:0] din_b,
    input  logic [ADDR_W-1:0] addrr_a,
    input  logic [ADDR_W-1:0] addrr_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done,
    output logic              wr_coll
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_coll_q, wr_coll_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        wr_coll_d  = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            IDLE: begin
                // B is applied after A so it overrides on an address match
                if (we_a) mem_d[addrw_a] = din_a;
                if (we_b) mem_d[addrw_b] = din_b;
                wr_coll_d = we_a && we_b && (addrw_a == addrw_b);
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == LAST) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
            wr_coll_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            wr_coll_q  <= wr_coll_d;
        end
    end

    // Storage has no reset so an aborted sweep leaves untouched words intact
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [DATA_W-1:0] dout_a_q, dout_a_d;
            logic [DATA_W-1:0] dout_b_q, dout_b_d;

            // Sampling the post-write image gives write-through with B over A
            always_comb begin
                dout_a_d = mem_d[addrr_a];
                dout_b_d = mem_d[addrr_b];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_a_q <= '0;
                    dout_b_q <= '0;
                end else begin
                    dout_a_q <= dout_a_d;
                    dout_b_q <= dout_b_d;
                end
            end

            assign dout_a = dout_a_q;
            assign dout_b = dout_b_q;
        end else begin : g_rd_comb
            assign dout_a = mem_q[addrr_a];
            assign dout_b = mem_q[addrr_b];
        end
    endgenerate

    assign busy     = (state_q == CLEAR);
    assign clr_done = clr_done_q;
    assign wr_coll  = wr_coll_q;
endmodule

// File: tb/tb_coef_regfile_2r2w.sv
// tb/tb_coef_regfile_2r2w.sv - self-checking bench for coef_regfile_2r2w
module tb_coef_regfile_2r2w;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_a, we_b, clr_start;
    logic [7:0]  addrw_a, addrw_b, addrr_a, addrr_b;
    logic [11:0] din_a, din_b;
    logic [11:0] dout0_a, dout0_b, dout1_a, dout1_b;
    logic        busy0, busy1, done0, done1, coll0, coll1;

    logic        we2_a, we2_b, clr2;
    logic [3:0]  aw2_a, aw2_b, ar2_a, ar2_b;
    logic [15:0] din2_a, din2_b, dout2_a, dout2_b;
    logic        busy2, done2, coll2;

    logic [11:0] mm [256];
    bit          m_busy;
    int          m_idx;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    coef_regfile_2r2w u0 (
        .clk(clk), .rst(rst), .we_a(we_a), .we_b(we_b),
        .addrw_a(addrw_a), .addrw_b(addrw_b), .din_a(din_a), .din_b(din_b),
        .addrr_a(addrr_a), .addrr_b(addrr_b), .dout_a(dout0_a), .dout_b(dout0_b),
        .clr_start(clr_start), .busy(busy0), .clr_done(done0), .wr_coll(coll0)
    );

    coef_regfile_2r2w #(.RD_REG(1)) u1 (
        .clk(clk), .rst(rst), .we_a(we_a), .we_b(we_b),
        .addrw_a(addrw_a), .addrw_b(addrw_b), .din_a(din_a), .din_b(din_b),
        .addrr_a(addrr_a), .addrr_b(addrr_b), .dout_a(dout1_a), .dout_b(dout1_b),
        .clr_start(clr_start), .busy(busy1), .clr_done(done1), .wr_coll(coll1)
    );

    coef_regfile_2r2w #(.DATA_W(16), .ADDR_W(4)) u2 (
        .clk(clk), .rst(rst), .we_a(we2_a), .we_b(we2_b),
        .addrw_a(aw2_a), .addrw_b(aw2_b), .din_a(din2_a), .din_b(din2_b),
        .addrr_a(ar2_a), .addrr_b(ar2_b), .dout_a(dout2_a), .dout_b(dout2_b),
        .clr_start(clr2), .busy(busy2), .clr_done(done2), .wr_coll(coll2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: memory as an array, the sweep as "word index being zeroed"
    task automatic step();
        bit e_coll, e_done;
        e_coll = 1'b0;
        e_done = 1'b0;
        if (m_busy) begin
            mm[m_idx] = '0;
            if (m_idx == 255) begin
                m_busy = 1'b0;
                e_done = 1'b1;
            end else begin
                m_idx++;
            end
        end else begin
            if (we_a) mm[addrw_a] = din_a;
            if (we_b) mm[addrw_b] = din_b;
            e_coll = we_a && we_b && (addrw_a == addrw_b);
            if (clr_start) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("busy", busy0, m_busy);
        chk("busy_reg", busy1, m_busy);
        chk("clr_done", done0, e_done);
        chk("clr_done_reg", done1, e_done);
        chk("wr_coll", coll0, e_coll);
        chk("wr_coll_reg", coll1, e_coll);
        chk("dout_a_comb", dout0_a, mm[addrr_a]);
        chk("dout_b_comb", dout0_b, mm[addrr_b]);
        chk("dout_a_reg", dout1_a, mm[addrr_a]);
        chk("dout_b_reg", dout1_b, mm[addrr_b]);
    endtask

    task automatic fill();
        for (int i = 0; i < 128; i++) begin
            we_a = 1'b1; we_b = 1'b1;
            addrw_a = 8'(2 * i); addrw_b = 8'(2 * i + 1);
            din_a = 12'($urandom); din_b = 12'($urandom);
            addrr_a = addrw_a; addrr_b = addrw_b;
            step();
        end
        we_a = 1'b0; we_b = 1'b0;
    endtask

    initial begin
        int nb, nd;
        logic [11:0] old, pre100, pre255;
        we_a = 0; we_b = 0; clr_start = 0;
        addrw_a = 0; addrw_b = 0; addrr_a = 0; addrr_b = 0; din_a = 0; din_b = 0;
        we2_a = 0; we2_b = 0; clr2 = 0;
        aw2_a = 0; aw2_b = 0; ar2_a = 0; ar2_b = 0; din2_a = 0; din2_b = 0;
        m_busy = 1'b0; m_idx = 0;

        #12;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_coll", coll1, 0);
        chk("rst_dout_reg_a", dout1_a, 0);
        chk("rst_dout_reg_b", dout1_b, 0);
        @(posedge clk); #1; rst = 1'b0;

        fill();

        we_a = 1; addrw_a = 8'h10; din_a = 12'h123;
        we_b = 1; addrw_b = 8'h20; din_b = 12'hABC;
        addrr_a = 8'h10; addrr_b = 8'h20;
        step();
        we_a = 0; we_b = 0;
        chk("dflt_a", dout0_a, 12'h123);
        chk("dflt_b", dout0_b, 12'hABC);

        we_a = 1; we_b = 1; addrw_a = 8'h05; addrw_b = 8'h05;
        din_a = 12'h111; din_b = 12'h222; addrr_a = 8'h05;
        step();
        chk("coll_flag", coll0, 1);
        chk("coll_data", dout0_a, 12'h222);
        we_a = 0; we_b = 0;
        step();
        chk("coll_clear", coll0, 0);

        addrr_a = 8'h07; we_a = 1; addrw_a = 8'h07; din_a = 12'h0FF;
        old = mm[7];
        #1;
        chk("comb_pre_edge", dout0_a, old);
        step();
        chk("fwd_a", dout1_a, 12'h0FF);
        we_a = 0; addrr_a = 8'h08;
        #1;
        chk("reg_hold", dout1_a, 12'h0FF);
        step();
        chk("reg_next", dout1_a, mm[8]);

        for (int i = 0; i < 300; i++) begin
            we_a = 1'($urandom); we_b = 1'($urandom);
            addrw_a = 8'($urandom_range(0, 15)); addrw_b = 8'($urandom_range(0, 15));
            din_a = 12'($urandom); din_b = 12'($urandom);
            addrr_a = 8'($urandom); addrr_b = 8'($urandom_range(0, 15));
            step();
        end
        we_a = 0; we_b = 0;

        clr_start = 1; step(); clr_start = 0;
        nb = 0; nd = 0;
        while (busy0 && nb < 300) begin
            we_a = 1; we_b = 1'($urandom);
            addrw_a = 8'($urandom); addrw_b = 8'($urandom);
            din_a = 12'($urandom | 1); din_b = 12'($urandom | 1);
            clr_start = ((nb % 37) == 5);
            addrr_a = 8'($urandom); addrr_b = 8'($urandom);
            step();
            nb++;
            if (done0) nd++;
        end
        we_a = 0; we_b = 0; clr_start = 0;
        chk("sweep_len", nb, 256);
        chk("sweep_done_cnt", nd, 1);
        for (int i = 0; i < 128; i++) begin
            addrr_a = 8'(2 * i); addrr_b = 8'(2 * i + 1);
            step();
            chk("cleared_a", dout0_a, 0);
            chk("cleared_b", dout0_b, 0);
        end

        fill();
        pre100 = mm[100]; pre255 = mm[255];
        clr_start = 1; step(); clr_start = 0;
        for (int k = 0; k < 100; k++) step();
        rst = 1'b1; m_busy = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_dout_reg", dout1_a, 0);
        @(posedge clk); #1;
        chk("abort_no_done", done1, 0);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) begin
            addrr_a = 8'(i); addrr_b = 8'(i + 128);
            step();
        end
        addrr_a = 8'd99; addrr_b = 8'd100;
        #1;
        chk("abort_w99", dout0_a, 0);
        chk("abort_w100", dout0_b, pre100);
        addrr_b = 8'd255;
        #1;
        chk("abort_w255", dout0_b, pre255);

        we2_a = 1; aw2_a = 4'd15; din2_a = 16'hFFFF; ar2_a = 4'd15;
        step();
        we2_a = 0;
        chk("small_rd", dout2_a, 16'hFFFF);
        clr2 = 1; step(); clr2 = 0;
        nb = 0; nd = 0;
        while (busy2 && nb < 40) begin
            step();
            nb++;
            if (done2) nd++;
        end
        chk("small_sweep_len", nb, 16);
        chk("small_done_cnt", nd, 1);
        chk("small_cleared", dout2_a, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/coef_regfile_2r2w.md
COEF_REGFILE_2R2W -- requirements
Module: coef_regfile_2r2w

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, coefficient width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 8, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter RD_REG, default 0; 0 = combinational read, 1 = registered read with 1-cycle latency.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 we_a / we_b  in  1 each  per-port write enables.
REQ-008 addrw_a / addrw_b  in  ADDR_W each  write addresses.
REQ-009 din_a / din_b  in  DATA_W each  write data.
REQ-010 addrr_a / addrr_b  in  ADDR_W each  read addresses.
REQ-011 dout_a / dout_b  out  DATA_W each  read data.
REQ-012 clr_start  in  1  single-cycle request to zero the whole array.
REQ-013 busy  out  1  high while a clear sweep runs.
REQ-014 clr_done  out  1  single-cycle pulse when a sweep completes.
REQ-015 wr_coll  out  1  registered flag, high one cycle after both ports wrote the same address.

Function
REQ-016 SHALL hold DEPTH words of DATA_W bits in flip-flop storage, with 2 independent read ports and 2 independent write ports.
REQ-017 On a rising edge with we_a=1 and not busy, SHALL write din_a to addrw_a; same for port B.
REQ-018 If both ports write the same address in one cycle, SHALL store din_b (port B wins) and set wr_coll=1 in the next cycle only.
REQ-019 With RD_REG=0, dout_x SHALL equal mem[addrr_x] combinationally; a same-cycle write SHALL be visible only after the edge.
REQ-020 With RD_REG=1, dout_x SHALL present on cycle N+1 the word at the addrr_x sampled on cycle N; if a write to that address occurs on edge N, dout_x SHALL show the newly written data, resolved port B over port A.
REQ-021 The FSM SHALL have states IDLE and CLEAR.
REQ-022 IDLE -> CLEAR on clr_start=1: counter loads 0 and busy rises on the next edge.
REQ-023 In CLEAR, the block SHALL write 0 to mem[counter] each cycle, increment the counter, and ignore we_a/we_b.
REQ-024 When the counter is DEPTH-1 and that word is written, the FSM SHALL return to IDLE, deassert busy, and pulse clr_done for exactly 1 cycle; total sweep = DEPTH cycles of busy.
REQ-025 clr_start while busy SHALL be ignored; the sweep SHALL not restart.
REQ-026 Reads during CLEAR SHALL return current contents; already-cleared words read 0.
REQ-027 The counter SHALL not wrap past DEPTH-1; no word is written twice per sweep.
REQ-028 wr_coll SHALL be 0 during CLEAR because writes are ignored.

Reset
REQ-029 rst=1 SHALL immediately force the FSM to IDLE, counter=0, busy=0, clr_done=0, wr_coll=0, and registered dout_a/dout_b=0 when RD_REG=1.
REQ-030 Reset SHALL not alter memory contents.
REQ-031 Reset during CLEAR SHALL abort the sweep with no clr_done pulse; words already zeroed stay zero and the rest are unchanged.
REQ-032 After rst deasserts, the first rising edge SHALL accept writes and clr_start normally.

Verification
REQ-033 Defaults: write A@0x10=0x123 and B@0x20=0xABC in one cycle, then read both -> dout_a=0x123, dout_b=0xABC.
REQ-034 Both ports write 0x05 with A=0x111 and B=0x222 -> mem[0x05]=0x222, wr_coll=1 for exactly the next cycle.
REQ-035 RD_REG=1: read addr 0x07 while port A writes 0x0FF to 0x07 -> next-cycle dout_a=0x0FF; with no write, it shows the old value one cycle later.
REQ-036 Fill all 256 words, then pulse clr_start -> busy high 256 cycles, one clr_done pulse, all reads 0, and writes issued during busy are discarded.
REQ-037 Assert rst at sweep cycle 100 -> busy=0 at once, no clr_done, words 0..99 read 0, words from 100 onward hold prior data.
REQ-038 DATA_W=16, ADDR_W=4: sweep takes 16 cycles, and writing 0xFFFF to address 15 reads back 0xFFFF.
